conv_line_ram: RTL and testbench

- Parametrised simple-dual-port synchronous RAM.
- Serves as the line/weight buffer for the 2D convolution datapath.
- Provides independent read and write ports, a configurable read latency and a read-valid strobe.
- After every reset, a built-in clear sequencer zeroes the whole array before the RAM accepts traffic.

---
 rtl/conv_line_ram.sv | 86 ++++++++
 tb/tb_conv_line_ram.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/conv_line_ram.sv
// conv_line_ram: simple-dual-port line/weight buffer with clear-after-reset sequencer
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   wr, wr_addr, din  write port
//   rd, rd_addr       read port request
//   dout, rd_valid    read result and its one-cycle valid strobe (RD_LAT cycles after rd)
//   busy              clear sequence running, rd/wr ignored
//   err               sticky out-of-range access flag
module conv_line_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8,
    parameter int RD_LAT = 1,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] din,
    input  logic              rd,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] dout,
    output logic              rd_valid,
    output logic              busy,
    output logic              err
);
    typedef enum logic {CLEAR, RUN} state_t;
    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] q1, rdata, mem_wd;
    logic [ADDR_W-1:0] mem_wa;
    logic              v1, run, wr_in, rd_in, mem_we;
    always_comb begin
        run    = state == RUN;
        wr_in  = {1'b0, wr_addr} < (ADDR_W+1)'(DEPTH);
        rd_in  = {1'b0, rd_addr} < (ADDR_W+1)'(DEPTH);
        mem_we = !reset && (run ? wr && wr_in : 1'b1);
        mem_wa = run ? wr_addr : ptr;
        mem_wd = run ? din : '0;
        // out-of-range reads return zero; same-address write can forward din
        rdata  = !rd_in ? '0 :
                 (BYPASS != 0 && wr && wr_in && wr_addr == rd_addr) ? din : mem[rd_addr];
    end
    always_ff @(posedge clk)
        if (mem_we) mem[mem_wa] <= mem_wd;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            ptr   <= '0;
            q1    <= '0;
            v1    <= 1'b0;
            err   <= 1'b0;
        end else begin
            v1 <= run && rd;
            if (run && rd) q1 <= rdata;
            if (run && ((wr && !wr_in) || (rd && !rd_in))) err <= 1'b1;
            if (!run) begin
                ptr <= ptr + 1'b1;
                if (ptr == ADDR_W'(DEPTH - 1)) state <= RUN;
            end
        end
    end
    assign busy = state == CLEAR;
    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] q2;
            logic              v2;
            always_ff @(posedge clk) begin
                if (reset) begin
                    q2 <= '0;
                    v2 <= 1'b0;
                end else begin
                    v2 <= v1;
                    if (v1) q2 <= q1;
                end
            end
            assign dout     = q2;
            assign rd_valid = v2;
        end else begin : g_lat1
            assign dout     = q1;
            assign rd_valid = v1;
        end
    endgenerate
endmodule

// File: tb/tb_conv_line_ram.sv
// tb_conv_line_ram: directed checks of three conv_line_ram builds (lat1/bypass, lat2/no-bypass, depth6)
module tb_conv_line_ram;
    logic       clk = 1'b0;
    logic       reset, wr, rd, wr2, rd2;
    logic [2:0] wr_addr, rd_addr, wa2, ra2;
    logic [7:0] din, din2, dout0, dout1, dout2;
    logic       rv0, rv1, rv2, busy0, busy1, busy2, err0, err1, err2;
    int         checks = 0;
    int         errors = 0;
    always #5 clk = ~clk;
    conv_line_ram #(.DATA_W(8), .ADDR_W(3), .DEPTH(8), .RD_LAT(1), .BYPASS(1)) u0 (
        .clk(clk), .reset(reset), .wr(wr), .wr_addr(wr_addr), .din(din), .rd(rd), .rd_addr(rd_addr),
        .dout(dout0), .rd_valid(rv0), .busy(busy0), .err(err0));
    conv_line_ram #(.DATA_W(8), .ADDR_W(3), .DEPTH(8), .RD_LAT(2), .BYPASS(0)) u1 (
        .clk(clk), .reset(reset), .wr(wr), .wr_addr(wr_addr), .din(din), .rd(rd), .rd_addr(rd_addr),
        .dout(dout1), .rd_valid(rv1), .busy(busy1), .err(err1));
    conv_line_ram #(.DATA_W(8), .ADDR_W(3), .DEPTH(6), .RD_LAT(1), .BYPASS(1)) u2 (
        .clk(clk), .reset(reset), .wr(wr2), .wr_addr(wa2), .din(din2), .rd(rd2), .rd_addr(ra2),
        .dout(dout2), .rd_valid(rv2), .busy(busy2), .err(err2));
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    initial begin
        reset = 1; wr = 0; rd = 0; wr_addr = 0; rd_addr = 0; din = 0;
        wr2 = 0; rd2 = 0; wa2 = 0; ra2 = 0; din2 = 0;
        tick; tick;
        chk("rst_busy", {busy0, busy1, busy2}, 3'b111);
        chk("rst_valid", {rv0, rv1, rv2}, 3'b000);
        chk("rst_err", {err0, err1, err2}, 3'b000);
        chk("rst_dout", {dout0, dout1, dout2}, 24'h0);
        // traffic during clear must be ignored
        reset = 0; rd = 1; rd_addr = 5; wr = 1; wr_addr = 1; din = 8'h77;
        for (int n = 1; n <= 8; n++) begin
            tick;
            chk("clr_busy8", {busy0, busy1}, (n < 8) ? 2'b11 : 2'b00);
            chk("clr_busy6", busy2, n < 6);
            chk("clr_valid", {rv0, rv1}, 2'b00);
        end
        wr = 0;
        for (int a = 0; a < 8; a++) begin
            rd = 1; rd_addr = 3'(a);
            tick;
            chk("clr_rd0", {rv0, dout0}, 9'h100);
            if (a > 0) chk("clr_rd1", {rv1, dout1}, 9'h100);
        end
        rd = 0;
        tick;
        chk("clr_rd1_last", {rv1, dout1}, 9'h100);
        chk("clr_rd0_idle", rv0, 0);
        tick;
        chk("clr_rd1_idle", rv1, 0);
        wr = 1; wr_addr = 3; din = 8'hA5;
        tick;
        wr = 0;
        chk("lat_wr_novalid", rv0, 0);
        rd = 1; rd_addr = 3;
        tick;
        rd = 0;
        chk("lat1_rd", {rv0, dout0}, 9'h1A5);
        chk("lat2_wait", rv1, 0);
        tick;
        chk("lat1_hold", {rv0, dout0}, 9'h0A5);
        chk("lat2_rd", {rv1, dout1}, 9'h1A5);
        tick;
        chk("lat2_hold", {rv1, dout1}, 9'h0A5);
        chk("lat1_hold2", dout0, 8'hA5);
        wr = 1; wr_addr = 2; din = 8'h11;
        tick;
        din = 8'h22; rd = 1; rd_addr = 2;
        tick;
        wr = 0; rd = 0;
        chk("rdw_bypass", {rv0, dout0}, 9'h122);
        tick;
        chk("rdw_old", {rv1, dout1}, 9'h111);
        rd = 1;
        tick;
        rd = 0;
        chk("rdw_after0", {rv0, dout0}, 9'h122);
        tick;
        chk("rdw_after1", {rv1, dout1}, 9'h122);
        for (int a = 0; a < 8; a++) begin
            wr = 1; wr_addr = 3'(a); din = 8'(a * 3);
            tick;
        end
        wr = 0;
        for (int a = 0; a < 8; a++) begin
            rd = 1; rd_addr = 3'(a);
            tick;
            chk("strm0", {rv0, dout0}, {1'b1, 8'(a * 3)});
            if (a > 0) chk("strm1", {rv1, dout1}, {1'b1, 8'((a - 1) * 3)});
        end
        rd = 0;
        tick;
        chk("strm1_last", {rv1, dout1}, 9'h115);
        chk("strm0_idle", {rv0, dout0}, 9'h015);
        wr2 = 1; wa2 = 5; din2 = 8'h5A;
        tick;
        wr2 = 0; rd2 = 1; ra2 = 5;
        tick;
        rd2 = 0;
        chk("oor_pre_rd", {rv2, dout2}, 9'h15A);
        chk("oor_pre_err", err2, 0);
        wr2 = 1; wa2 = 7; din2 = 8'hFF;
        tick;
        wr2 = 0;
        chk("oor_wr_err", err2, 1);
        rd2 = 1; ra2 = 7;
        tick;
        rd2 = 0;
        chk("oor_rd", {rv2, dout2}, 9'h100);
        for (int a = 0; a < 6; a++) begin
            rd2 = 1; ra2 = 3'(a);
            tick;
            chk("oor_keep", {rv2, dout2}, {1'b1, (a == 5) ? 8'h5A : 8'h00});
        end
        rd2 = 0;
        tick;
        chk("oor_sticky", err2, 1);
        chk("inr_noerr", {err0, err1}, 2'b00);
        reset = 1;
        tick;
        reset = 0;
        for (int n = 0; n < 4; n++) tick;
        reset = 1;
        tick;
        reset = 0;
        chk("mid_rst_err", err2, 0);
        for (int n = 1; n <= 8; n++) begin
            tick;
            chk("mid_busy", busy0, n < 8);
        end
        rd = 1; rd_addr = 3;
        tick;
        rd = 0;
        chk("mid_cleared", {rv0, dout0}, 9'h100);
        wr = 1; wr_addr = 3; din = 8'h3C;
        tick;
        wr = 0; rd = 1;
        tick;
        rd = 0; reset = 1;
        tick;
        reset = 0;
        chk("flight_drop", {rv1, dout1}, 9'h000);
        tick;
        chk("flight_drop2", {rv1, dout1}, 9'h000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
